mem_access_stage: RTL

- MEM pipeline stage. Consumes the EX→MEM payload: ALU result/address, rs2 store data, MemOP, MemWr, RegSrc, inst, pc.
- Performs loads and stores over a valid/ready data-bus handshake with byte-lane alignment and load extension.
- Hands a registered result to WB. Non-memory instructions pass through in one cycle.

---
 rtl/mem_access_stage.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_stage.sv
// mem_access_stage -- MEM pipeline stage.
//
// Takes the EX->MEM payload and does one of two things with it:
//  - Non-memory instructions go to WB one cycle after they are accepted.
//  - Loads and stores make a single request on a valid/ready data bus. The
//    request uses an 8-byte aligned address, byte strobes and lane-shifted
//    store data. For loads, the returned word is shifted down and sign- or
//    zero-extended before it goes to WB.
// Every output is a register. The stage holds at most one instruction, so
// throughput is at most one instruction per two cycles.
//
// Optional feature (macro MEM_MISALIGN_TRAP_EN):
//   defined   - a misaligned memory access makes no bus request. It goes
//               straight to OUT with misalign=1 and wb_data=alu_res.
//   undefined - misalign is tied 0. The byte offset is silently rounded down
//               to a multiple of the access size.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   in_valid/in_ready  EX payload handshake (in_ready is high only in IDLE)
//   alu_res            address for memory ops, result for everything else
//   r_rs2              store data
//   mem_op             000 b, 001 h, 010 w, 011 d, 100 bu, 101 hu, 110 wu
//                      (111 behaves like d)
//   mem_wr             store
//   reg_src            01 = load result goes to WB
//   inst_i, pc_i       instruction and pc, passed through to WB
//   dbus_*             data-bus request (valid/ready) and response
//   out_valid/ready    WB payload handshake
//   wb_data            load result or alu_res
//   reg_src_o, inst_o, pc_o  registered copies for WB
//   misalign           misaligned-access flag
module mem_access_stage #(
  parameter int XLEN = 64,
  parameter int ILEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   alu_res,
  input  logic [XLEN-1:0]   r_rs2,
  input  logic [2:0]        mem_op,
  input  logic              mem_wr,
  input  logic [1:0]        reg_src,
  input  logic [ILEN-1:0]   inst_i,
  input  logic [XLEN-1:0]   pc_i,
  output logic              dbus_req_valid,
  input  logic              dbus_req_ready,
  output logic [XLEN-1:0]   dbus_addr,
  output logic              dbus_wen,
  output logic [XLEN-1:0]   dbus_wdata,
  output logic [XLEN/8-1:0] dbus_wmask,
  input  logic              dbus_resp_valid,
  input  logic [XLEN-1:0]   dbus_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   wb_data,
  output logic [1:0]        reg_src_o,
  output logic [ILEN-1:0]   inst_o,
  output logic [XLEN-1:0]   pc_o,
  output logic              misalign
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_OUT  = 2'd3
  } state_t;

  state_t          state_r;
  logic [OFFW-1:0] off_r;
  logic [2:0]      mem_op_r;
  logic            load_r;

  // Offset bits that must be zero for an access of 2**lg bytes to be aligned.
  function automatic logic [OFFW-1:0] size_low_mask(input logic [1:0] lg);
    logic [7:0] m;
    case (lg)
      2'd0:    m = 8'h00;
      2'd1:    m = 8'h01;
      2'd2:    m = 8'h03;
      default: m = 8'h07;
    endcase
    return m[OFFW-1:0];
  endfunction

  // Byte strobes for a 2**lg byte access at offset 0.
  function automatic logic [NB-1:0] base_strobe(input logic [1:0] lg);
    logic [7:0] m;
    case (lg)
      2'd0:    m = 8'h01;
      2'd1:    m = 8'h03;
      2'd2:    m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return NB'(m);
  endfunction

  // Shift the raw bus word down to the accessed lanes, then extend it.
  function automatic logic [XLEN-1:0] load_extend(input logic [XLEN-1:0] rdata,
                                                  input logic [OFFW-1:0] off,
                                                  input logic [2:0]      op);
    logic [XLEN-1:0] raw;
    logic [XLEN-1:0] res;
    raw = rdata >> {off, 3'b000};
    case (op)
      3'b000:  res = {{(XLEN-8){raw[7]}},   raw[7:0]};
      3'b001:  res = {{(XLEN-16){raw[15]}}, raw[15:0]};
      3'b010:  res = {{(XLEN-32){raw[31]}}, raw[31:0]};
      3'b100:  res = {{(XLEN-8){1'b0}},     raw[7:0]};
      3'b101:  res = {{(XLEN-16){1'b0}},    raw[15:0]};
      3'b110:  res = {{(XLEN-32){1'b0}},    raw[31:0]};
      default: res = raw;  // 011 d, and 111 treated as d
    endcase
    return res;
  endfunction

  logic            accept_s;
  logic            is_mem_s;
  logic            is_load_s;
  logic            misalign_s;
  logic [OFFW-1:0] off_raw_s;
  logic [OFFW-1:0] low_mask_s;
  logic [OFFW-1:0] off_eff_s;
  logic [NB-1:0]   wmask_s;
  logic [XLEN-1:0] wdata_s;
  logic [XLEN-1:0] addr_s;

  // Decode the incoming payload: classify it and build the bus request fields.
  always_comb begin
    accept_s   = in_valid & in_ready;
    is_mem_s   = mem_wr | (reg_src == 2'b01);
    is_load_s  = ~mem_wr & (reg_src == 2'b01);
    off_raw_s  = alu_res[OFFW-1:0];
    low_mask_s = size_low_mask(mem_op[1:0]);
`ifdef MEM_MISALIGN_TRAP_EN
    misalign_s = is_mem_s & (|(off_raw_s & low_mask_s));
    off_eff_s  = off_raw_s;
`else
    misalign_s = 1'b0;
    off_eff_s  = off_raw_s & ~low_mask_s;
`endif
    wmask_s    = base_strobe(mem_op[1:0]) << off_eff_s;
    wdata_s    = r_rs2 << {off_eff_s, 3'b000};
    addr_s     = {alu_res[XLEN-1:OFFW], {OFFW{1'b0}}};
  end

  // Stage FSM. All outputs are registered here, so they hold steady across stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= ST_IDLE;
      in_ready       <= 1'b1;
      out_valid      <= 1'b0;
      dbus_req_valid <= 1'b0;
      dbus_wen       <= 1'b0;
      dbus_addr      <= {XLEN{1'b0}};
      dbus_wdata     <= {XLEN{1'b0}};
      dbus_wmask     <= {NB{1'b0}};
      misalign       <= 1'b0;
      wb_data        <= {XLEN{1'b0}};
      inst_o         <= {ILEN{1'b0}};
      pc_o           <= {XLEN{1'b0}};
      reg_src_o      <= 2'b00;
      off_r          <= {OFFW{1'b0}};
      mem_op_r       <= 3'b000;
      load_r         <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            in_ready  <= 1'b0;
            inst_o    <= inst_i;
            pc_o      <= pc_i;
            reg_src_o <= reg_src;
            wb_data   <= alu_res;
            off_r     <= off_eff_s;
            mem_op_r  <= mem_op;
            load_r    <= is_load_s;
            if (is_mem_s && !misalign_s) begin
              state_r        <= ST_REQ;
              dbus_req_valid <= 1'b1;
              dbus_addr      <= addr_s;
              dbus_wen       <= mem_wr;
              dbus_wdata     <= mem_wr ? wdata_s : {XLEN{1'b0}};
              dbus_wmask     <= mem_wr ? wmask_s : {NB{1'b0}};
            end else begin
              // Non-memory op, or a trapped misaligned access: no bus traffic.
              state_r   <= ST_OUT;
              out_valid <= 1'b1;
              misalign  <= misalign_s;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_REQ: begin
          if (dbus_req_ready) begin
            state_r        <= ST_WAIT;
            dbus_req_valid <= 1'b0;
          end else begin
            state_r <= ST_REQ;
          end
        end
        ST_WAIT: begin
          if (dbus_resp_valid) begin
            state_r   <= ST_OUT;
            out_valid <= 1'b1;
            if (load_r) begin
              wb_data <= load_extend(dbus_rdata, off_r, mem_op_r);
            end else begin
              wb_data <= wb_data;  // store: WB sees alu_res
            end
          end else begin
            state_r <= ST_WAIT;
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            state_r   <= ST_IDLE;
            out_valid <= 1'b0;
            misalign  <= 1'b0;
            in_ready  <= 1'b1;
          end else begin
            state_r <= ST_OUT;
          end
        end
        default: begin
          state_r        <= ST_IDLE;
          in_ready       <= 1'b1;
          out_valid      <= 1'b0;
          dbus_req_valid <= 1'b0;
          misalign       <= 1'b0;
        end
      endcase
    end
  end

endmodule
